svc_rv_bram_arb: RTL

- Two-requester arbiter sharing one single-port, 1-cycle-read-latency BRAM between the RV core data port (m0) and a secondary master such as a debug/DMA loader (m1).
- Sits between the SoC data bus and the data memory instance.
- Grants one access per cycle.
- Routes returning read data back to the master that issued the read.
- Policy is m0 priority with a starvation guard on m1.

---
 rtl/svc_rv_bram_arb_pkg.sv | 13 +
 rtl/svc_rv_bram_arb_pick.sv | 25 ++
 rtl/svc_rv_bram_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/svc_rv_bram_arb_pkg.sv
// Shared types for the two-master BRAM arbiter (svc_rv_bram_arb).
// Read-owner encoding and the starvation counter width live here.
package svc_rv_bram_arb_pkg;

   localparam int STARVE_CW = 8;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_M0   = 2'd1,
      OWNER_M1   = 2'd2
   } owner_t;

endpackage

// File: rtl/svc_rv_bram_arb_pick.sv
// Combinational grant selector for svc_rv_bram_arb; the result is one-hot or zero.
// On contention m0 wins unless m1 is starving or m0 was the last master served.
module svc_rv_bram_arb_pick
   import svc_rv_bram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       starve,
   input  owner_t     last_gnt,
   output logic [1:0] gnt
);

   logic prefer_m1;

   always_comb begin
      gnt       = 2'b00;
      prefer_m1 = starve || (last_gnt == OWNER_M0);
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prefer_m1 ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/svc_rv_bram_arb.sv
// Two-master arbiter for one single-port, 1-cycle-latency BRAM (m0 = core, m1 = loader).
// Default: m0 priority with an m1 starvation guard; define SVC_RV_BRAM_ARB_RR_EN for round-robin.
module svc_rv_bram_arb
   import svc_rv_bram_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_wstrb,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_wstrb,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,
   output logic            mem_ren,
   output logic [AW-1:0]   mem_raddr,
   input  logic [DW-1:0]   mem_rdata,
   output logic            mem_wen,
   output logic [AW-1:0]   mem_waddr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb
);

   logic [1:0] pick_gnt;
   logic [1:0] gnt;
   logic       starve;
   owner_t     last_gnt;
   owner_t     rd_owner_d, rd_owner_q;

`ifdef SVC_RV_BRAM_ARB_RR_EN
   owner_t last_gnt_d, last_gnt_q;

   assign starve   = 1'b0;
   assign last_gnt = last_gnt_q;

   always_comb begin
      last_gnt_d = last_gnt_q;
      if (gnt[0])      last_gnt_d = OWNER_M0;
      else if (gnt[1]) last_gnt_d = OWNER_M1;
   end

   // Reset to M1 so the first contention after reset goes to m0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_gnt_q <= OWNER_M1;
      else     last_gnt_q <= last_gnt_d;
   end
`else
   localparam logic [STARVE_CW-1:0] LIMIT = STARVE_CW'(STARVE_LIMIT);

   logic [STARVE_CW-1:0] starve_cnt_d, starve_cnt_q;

   assign starve   = (starve_cnt_q == LIMIT);
   assign last_gnt = OWNER_M1;

   always_comb begin
      starve_cnt_d = '0;
      if (m1_req && !gnt[1])
         starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_cnt_q <= '0;
      else     starve_cnt_q <= starve_cnt_d;
   end
`endif

   svc_rv_bram_arb_pick u_pick (
      .req      ({m1_req, m0_req}),
      .starve   (starve),
      .last_gnt (last_gnt),
      .gnt      (pick_gnt)
   );

   assign gnt    = pick_gnt & {2{~rst}};
   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   always_comb begin
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_raddr = '0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      if (gnt[0]) begin
         mem_ren   = !m0_we;
         mem_wen   = m0_we;
         mem_raddr = m0_we ? '0 : m0_addr;
         mem_waddr = m0_we ? m0_addr : '0;
         mem_wdata = m0_we ? m0_wdata : '0;
         mem_wstrb = m0_we ? m0_wstrb : '0;
      end else if (gnt[1]) begin
         mem_ren   = !m1_we;
         mem_wen   = m1_we;
         mem_raddr = m1_we ? '0 : m1_addr;
         mem_waddr = m1_we ? m1_addr : '0;
         mem_wdata = m1_we ? m1_wdata : '0;
         mem_wstrb = m1_we ? m1_wstrb : '0;
      end
   end

   always_comb begin
      rd_owner_d = OWNER_NONE;
      if (gnt[0] && !m0_we)      rd_owner_d = OWNER_M0;
      else if (gnt[1] && !m1_we) rd_owner_d = OWNER_M1;
   end

   // Async clear drops any read accepted as reset arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_owner_q <= OWNER_NONE;
      else     rd_owner_q <= rd_owner_d;
   end

   assign m0_rvalid = (rd_owner_q == OWNER_M0);
   assign m1_rvalid = (rd_owner_q == OWNER_M1);
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

endmodule
